// File: rtl/neuron_mac.sv
// Serial Q8.8 multiply-accumulate for one neuron: z = bias + sum(x*w), accumulated
// in Q16.16 and then floored and saturated back to a 16-bit Q8.8 result.
module neuron_mac #(
   parameter int N_INPUTS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] bias_in,
   input  logic [15:0] x_in,
   input  logic [15:0] w_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] acc_out,
   output logic        done,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      SAT,
      DONE
   } state_t;

   localparam logic [8:0]         LAST_PAIR = 9'(N_INPUTS - 1);
   localparam logic signed [39:0] SAT_HI    = 40'sh0000800000;
   localparam logic signed [39:0] SAT_LO    = 40'shFFFF800000;

   state_t             state;
   logic [8:0]         count;
   logic signed [39:0] acc;
   logic signed [31:0] product;
   logic [15:0]        sat_value;

   assign product = $signed(x_in) * $signed(w_in);

   // Floor by dropping the 8 fraction bits; bounds are compared on the unshifted sum.
   always_comb begin
      sat_value = acc[23:8];
      if (acc >= SAT_HI) begin
         sat_value = 16'h7FFF;
      end else if (acc < SAT_LO) begin
         sat_value = 16'h8000;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         acc      <= '0;
         count    <= '0;
         acc_out  <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
         in_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc      <= {{16{bias_in[15]}}, bias_in, 8'h00};
                  count    <= '0;
                  busy     <= 1'b1;
                  in_ready <= 1'b1;
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  acc   <= acc + {{8{product[31]}}, product};
                  count <= count + 9'd1;
                  if (count == LAST_PAIR) begin
                     in_ready <= 1'b0;
                     state    <= SAT;
                  end
               end
            end
            SAT: begin
               acc_out <= sat_value;
               done    <= 1'b1;
               state   <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               done     <= 1'b0;
               busy     <= 1'b0;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac (N_INPUTS=4): values, latency, stalls, held start,
// asynchronous reset mid-run and back-to-back neurons.
module tb_neuron_mac;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] bias_in;
   logic [15:0] x_in;
   logic [15:0] w_in;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] acc_out;
   logic        done;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int cycle_count = 0;
   int done_pulses = 0;

   logic [15:0] xv [4];
   logic [15:0] wv [4];

   int          run_latency;
   logic [15:0] run_result;
   int          run_done_count;
   logic        run_done_after;
   logic        run_early_change;
   int          run_done_cycle;

   neuron_mac #(.N_INPUTS(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bias_in  (bias_in),
      .x_in     (x_in),
      .w_in     (w_in),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .acc_out  (acc_out),
      .done     (done),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_count++;

   always @(negedge clk) if (done) done_pulses++;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic setPairs(input logic [15:0] x0, w0, x1, w1, x2, w2, x3, w3);
      xv[0] = x0; wv[0] = w0;
      xv[1] = x1; wv[1] = w1;
      xv[2] = x2; wv[2] = w2;
      xv[3] = x3; wv[3] = w3;
   endtask

   // Runs one neuron from start until the cycle after done, with an optional stall window.
   task automatic applyStimulus(input logic [15:0] bias, input int stall_after, input int stall_len,
                                input bit hold_start);
      int          idx;
      int          stalled;
      int          cyc;
      bit          hs;
      logic [15:0] prev_out;
      prev_out         = acc_out;
      run_latency      = -1;
      run_result       = 16'hxxxx;
      run_done_count   = 0;
      run_done_after   = 1'bx;
      run_early_change = 1'b0;
      run_done_cycle   = -1;
      idx     = 0;
      stalled = 0;
      cyc     = 0;
      start    = 1'b1;
      bias_in  = bias;
      in_valid = 1'b0;
      @(posedge clk); #1;
      if (!hold_start) start = 1'b0;
      bias_in = 16'hA5A5;
      while (cyc < 40) begin
         if (idx < 4 && !(idx == stall_after && stalled < stall_len)) begin
            in_valid = 1'b1;
            x_in     = xv[idx];
            w_in     = wv[idx];
         end else begin
            in_valid = 1'b0;
            x_in     = 16'h7FFF;
            w_in     = 16'h7FFF;
            if (idx == stall_after && stalled < stall_len) stalled++;
         end
         hs = in_valid && in_ready;
         @(posedge clk); #1;
         cyc++;
         if (hs) idx++;
         if (run_latency >= 0 && cyc == run_latency + 1) begin
            run_done_after = done;
            break;
         end
         if (done) begin
            run_done_count++;
            if (run_latency < 0) begin
               run_latency    = cyc;
               run_result     = acc_out;
               run_done_cycle = cycle_count;
            end
         end else if (acc_out !== prev_out) begin
            run_early_change = 1'b1;
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic runAndCheck(input string tag, input logic [15:0] bias, input int stall_after,
                              input int stall_len, input int exp_latency, input logic [15:0] exp_value);
      applyStimulus(bias, stall_after, stall_len, 1'b0);
      checkOutput({tag, "_latency"}, 32'(run_latency), 32'(exp_latency));
      checkOutput({tag, "_value"}, {16'h0, run_result}, {16'h0, exp_value});
      checkOutput({tag, "_done_fall"}, {31'h0, run_done_after}, 32'h0);
      checkOutput({tag, "_held_before_done"}, {31'h0, run_early_change}, 32'h0);
   endtask

   initial begin
      int first_done;
      int pulses_before;
      reset    = 1'b1;
      start    = 1'b0;
      bias_in  = 16'h0000;
      x_in     = 16'h0000;
      w_in     = 16'h0000;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_acc_out", {16'h0, acc_out}, 32'h0);
      checkOutput("reset_done", {31'h0, done}, 32'h0);
      checkOutput("reset_busy", {31'h0, busy}, 32'h0);
      checkOutput("reset_in_ready", {31'h0, in_ready}, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      $display("[TB] basic sums");
      setPairs(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
      runAndCheck("basic", 16'h0000, 99, 0, 5, 16'h0400);
      checkOutput("basic_busy_after", {31'h0, busy}, 32'h0);
      runAndCheck("basic_bias", 16'hFF00, 99, 0, 5, 16'h0300);

      $display("[TB] saturation and floor");
      setPairs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      runAndCheck("sat_pos", 16'h0000, 99, 0, 5, 16'h7FFF);
      setPairs(16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF);
      runAndCheck("sat_neg", 16'h0000, 99, 0, 5, 16'h8000);
      setPairs(16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      runAndCheck("floor_pos", 16'h0000, 99, 0, 5, 16'h0000);
      setPairs(16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      runAndCheck("floor_neg", 16'h0000, 99, 0, 5, 16'hFFFF);

      $display("[TB] stalls");
      setPairs(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
      runAndCheck("stall", 16'h0000, 2, 3, 8, 16'h0400);

      $display("[TB] start held high");
      applyStimulus(16'h0000, 99, 0, 1'b1);
      start = 1'b1;
      checkOutput("hold_value", {16'h0, run_result}, 32'h0400);
      checkOutput("hold_done_count", 32'(run_done_count), 32'd1);
      checkOutput("hold_idle_busy", {31'h0, busy}, 32'h0);
      @(posedge clk); #1;
      checkOutput("hold_restart_busy", {31'h0, busy}, 32'h1);
      start = 1'b0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      @(posedge clk); #1;

      $display("[TB] reset mid-run");
      setPairs(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
      runAndCheck("pre_reset", 16'hFF00, 99, 0, 5, 16'h0300);
      start   = 1'b1;
      bias_in = 16'h0000;
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b1;
      x_in     = 16'h0100;
      w_in     = 16'h0100;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      checkOutput("midreset_acc_out", {16'h0, acc_out}, 32'h0);
      checkOutput("midreset_busy", {31'h0, busy}, 32'h0);
      checkOutput("midreset_in_ready", {31'h0, in_ready}, 32'h0);
      pulses_before = done_pulses;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("midreset_no_done", 32'(done_pulses), 32'(pulses_before));
      setPairs(16'h0200, 16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0100);
      runAndCheck("fresh", 16'h0000, 99, 0, 5, 16'h0800);

      $display("[TB] back-to-back");
      setPairs(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
      runAndCheck("b2b_first", 16'h0100, 99, 0, 5, 16'h0500);
      first_done = run_done_cycle;
      setPairs(16'h0080, 16'h0100, 16'h0080, 16'h0100, 16'h0080, 16'h0100, 16'h0080, 16'h0100);
      runAndCheck("b2b_second", 16'h0000, 99, 0, 5, 16'h0200);
      checkOutput("b2b_gap", 32'(run_done_cycle - first_done), 32'd7);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
